uart_cnt_tx_reporter: RTL and testbench

Transmit side of the board's UART link. On request it captures the 14-bit up-counter value, converts it to four ASCII decimal digits, and serialises "DDDD\r\n" as six 8N1 frames on the TX line. It sits next to the counter/FND path and mirrors the receive path that feeds `i_rx_data` into the run/clear FSM. The host can therefore read back the current count.

---
 rtl/uart_cnt_tx_reporter.sv | 169 ++++++++++++++++
 tb/tb_uart_cnt_tx_reporter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cnt_tx_reporter.sv
// UART transmit reporter: on request, captures the counter value and sends it as
// four ASCII decimal digits followed by CR LF, using 8N1 framing.
module uart_cnt_tx_reporter #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_value,
    input  logic        i_send,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    // state    | meaning
    // IDLE     | line high, waiting for i_send
    // CONVERT  | 14 shift-add-3 steps, then one cycle to load byte index 0
    // START    | start bit (low) for BIT_CYC cycles
    // DATA     | 8 data bits, LSB first, BIT_CYC cycles each
    // STOP     | stop bit (high); go to the next byte, or finish after CR LF
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;

    localparam int              BIT_CYC   = CLK_HZ / BAUD;
    localparam int              CW        = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BIT_CYC - 1);
    localparam logic [13:0]     VALUE_MAX = 14'd9999;
    localparam logic [3:0]      CONV_LAST = 4'd14;
    localparam logic [2:0]      BYTE_LAST = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    conv_cnt;
    logic [13:0]   bin_sr;
    logic [15:0]   bcd;
    logic [2:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_sr;

    logic [15:0]   bcd_adj;
    logic [29:0]   conv_shift;
    logic [15:0]   bcd_next;
    logic [13:0]   bin_next;
    logic [7:0]    cur_byte;
    logic          baud_end;
    logic [13:0]   value_sat;

    assign value_sat = (i_value > VALUE_MAX) ? VALUE_MAX : i_value;
    assign baud_end  = (baud_cnt == BAUD_LAST);

    // Double-dabble step: fix up each digit, then shift the whole BCD:binary word left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        conv_shift = {bcd_adj, bin_sr} << 1;
        bcd_next   = conv_shift[29:14];
        bin_next   = conv_shift[13:0];
    end

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = {4'h3, bcd[15:12]};
            3'd1:    cur_byte = {4'h3, bcd[11:8]};
            3'd2:    cur_byte = {4'h3, bcd[7:4]};
            3'd3:    cur_byte = {4'h3, bcd[3:0]};
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            conv_cnt <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            tx_sr    <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_tx <= 1'b1;
                    if (i_send) begin
                        bin_sr   <= value_sat;
                        bcd      <= '0;
                        conv_cnt <= '0;
                        o_busy   <= 1'b1;
                        state    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (conv_cnt == CONV_LAST) begin
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        o_tx     <= 1'b0;
                        state    <= S_START;
                    end else begin
                        bcd      <= bcd_next;
                        bin_sr   <= bin_next;
                        conv_cnt <= conv_cnt + 4'd1;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        o_tx     <= cur_byte[0];
                        tx_sr    <= {1'b0, cur_byte[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_tx  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= tx_sr[0];
                            tx_sr   <= tx_sr >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx != BYTE_LAST) begin
                            byte_idx <= byte_idx + 3'd1;
                            o_tx     <= 1'b0;
                            state    <= S_START;
                        end else begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cnt_tx_reporter.sv
// Scoreboard bench for uart_cnt_tx_reporter: expected bytes are queued at request
// time and compared as frames are decoded from o_tx.
module tb_uart_cnt_tx_reporter;

    localparam int BIT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] i_value = '0;
    logic        i_send = 1'b0;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_done = 0;
    logic [7:0]  exp_q[$];

    uart_cnt_tx_reporter #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_value (i_value),
        .i_send  (i_send),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_done === 1'b1) n_done <= n_done + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        exp_q.push_back(8'(8'h30 + (s / 1000)));
        exp_q.push_back(8'(8'h30 + ((s / 100) % 10)));
        exp_q.push_back(8'(8'h30 + ((s / 10) % 10)));
        exp_q.push_back(8'(8'h30 + (s % 10)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send(input int v, output int e0);
        @(negedge clk);
        i_value = 14'(v);
        i_send  = 1'b1;
        push_exp(v);
        @(negedge clk);
        i_send = 1'b0;
        e0 = cyc;
        chk("busy_after_accept", int'(o_busy), 1);
    endtask

    task automatic recv_frame(input int exp_start, input bit chk_start);
        int         t;
        bit         frame_ok;
        logic       v;
        logic [7:0] data;
        logic [7:0] exp_b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (o_tx !== 1'b0 && t < 4000);
        if (t >= 4000) begin
            chk("start_timeout", 0, 1);
            return;
        end
        if (chk_start) chk("start_latency", cyc, exp_start);
        frame_ok = 1'b1;
        data     = '0;
        v        = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) v = o_tx;
                else if (o_tx !== v) frame_ok = 1'b0;
            end
            if (b == 0 && v !== 1'b0) frame_ok = 1'b0;
            if (b == 9 && v !== 1'b1) frame_ok = 1'b0;
            if (b >= 1 && b <= 8) data[b-1] = v;
        end
        chk("framing", int'(frame_ok), 1);
        if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(data), -1);
        end else begin
            exp_b = exp_q.pop_front();
            chk("byte", int'(data), int'(exp_b));
        end
    endtask

    task automatic recv_seq(input int e0);
        for (int i = 0; i < 6; i++) recv_frame(e0 + 15, i == 0);
    endtask

    task automatic check_end(input int e0);
        @(negedge clk);
        chk("done_pulse", int'(o_done), 1);
        chk("done_latency", cyc - e0, 15 + 60 * BIT_CYC);
        chk("busy_at_done", int'(o_busy), 0);
        chk("tx_at_done", int'(o_tx), 1);
        @(negedge clk);
        chk("done_cleared", int'(o_done), 0);
    endtask

    task automatic quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int e0;
        int d0;

        // reset held for 3 cycles, then line must stay idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", int'(o_tx), 1);
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_done", int'(o_done), 0);
        end
        reset = 1'b1;
        quiet(100, "idle_after_reset");

        // basic send and boundaries
        d0 = n_done;
        send(1234, e0);
        recv_seq(e0);
        check_end(e0);
        chk("single_done_1234", n_done - d0, 1);

        send(0, e0);
        recv_seq(e0);
        check_end(e0);

        send(9999, e0);
        recv_seq(e0);
        check_end(e0);

        send(16383, e0);
        recv_seq(e0);
        check_end(e0);

        // requests and value changes while busy are ignored
        d0 = n_done;
        send(42, e0);
        fork
            recv_seq(e0);
            begin
                repeat (3) @(negedge clk);
                i_value = 14'd1111;
                repeat (15 + 2 * 10 * BIT_CYC + 40 - 3) @(negedge clk);
                i_value = 14'd7777;
                i_send  = 1'b1;
                @(negedge clk);
                i_send = 1'b0;
            end
        join
        check_end(e0);
        quiet(200, "no_second_sequence");
        chk("single_done_busy", n_done - d0, 1);

        // reset during data bit 2 of byte 3 ('3' = 0x33, bit 2 is 0)
        @(negedge clk);
        i_value = 14'd3333;
        i_send  = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        e0 = cyc;
        repeat (15 + 3 * 10 * BIT_CYC + 3 * BIT_CYC + 5) @(negedge clk);
        chk("pre_reset_tx_low", int'(o_tx), 0);
        chk("pre_reset_busy", int'(o_busy), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_tx", int'(o_tx), 1);
        chk("async_reset_busy", int'(o_busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet(20, "idle_after_abort");
        send(5, e0);
        recv_seq(e0);
        check_end(e0);

        // held request gives back-to-back sequences
        d0 = n_done;
        @(negedge clk);
        i_value = 14'd9;
        i_send  = 1'b1;
        push_exp(9);
        push_exp(9);
        @(negedge clk);
        e0 = cyc;
        recv_seq(e0);
        @(negedge clk);
        chk("b2b_done1", int'(o_done), 1);
        chk("b2b_done1_latency", cyc - e0, 15 + 60 * BIT_CYC);
        chk("b2b_idle_tx", int'(o_tx), 1);
        chk("b2b_idle_busy", int'(o_busy), 0);
        @(negedge clk);
        i_send = 1'b0;
        chk("b2b_reaccept_busy", int'(o_busy), 1);
        recv_seq(e0 + 15 + 60 * BIT_CYC + 1);
        check_end(e0 + 15 + 60 * BIT_CYC + 1);
        quiet(50, "idle_after_b2b");
        chk("b2b_done_count", n_done - d0, 2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
